// File: rtl/lcd12864_ctrl_if.sv
// Client write port of the ST7920-class 128x64 LCD controller.
// The client (text walker, counter display, ...) is the master and pushes
// command/data bytes; the controller is the slave and paces them with
// wr_ready. A byte moves when wr_valid and wr_ready are both high at a
// rising clock edge.
interface lcd12864_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;

    modport master (
        output wr_valid,
        output wr_rs,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_rs,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/lcd12864_ctrl.sv
// Write-only controller for an ST7920-class 128x64 LCD on an 8-bit parallel
// header. After reset it waits out LCD power-up, sends the init bytes
// 0x30, 0x0C, 0x06, 0x01 on its own, then serves client bytes from the
// valid/ready port. Every byte goes through the same timed strobe:
// setup (E low), E high, hold (E low), then a settle wait that is long
// for clear (0x01) and home (0x02) commands and short for everything else.
// All LCD pins come straight from flops so they never glitch.
module lcd12864_ctrl #(
    parameter int E_HALF_CYC    = 16,
    parameter int CMD_WAIT_CYC  = 4000,
    parameter int CLR_WAIT_CYC  = 90000,
    parameter int INIT_WAIT_CYC = 2500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lcd12864_ctrl_if.slave        wr,
    output logic                  init_done,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic                  lcd_en,
    output logic [7:0]            lcd_dat
);

    // Largest phase length decides the shared counter width.
    localparam int MAX_AB  = (E_HALF_CYC > CMD_WAIT_CYC) ? E_HALF_CYC : CMD_WAIT_CYC;
    localparam int MAX_CD  = (CLR_WAIT_CYC > INIT_WAIT_CYC) ? CLR_WAIT_CYC : INIT_WAIT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // A phase lasting N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(E_HALF_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Index of the last init byte (the clear command).
    localparam logic [1:0] INIT_LAST_IDX = 2'd3;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        SETUP,
        E_HIGH,
        HOLD,
        SETTLE,
        IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic             wr_ready_q, wr_ready_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_en_q, lcd_en_d;
    logic [7:0]       lcd_dat_q, lcd_dat_d;

    logic             long_settle;
    logic [CNT_W-1:0] settle_last;

    // Fixed init sequence: 8-bit basic set, display on, entry increment, clear.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h30;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h06;
            default: b = 8'h01;
        endcase
        return b;
    endfunction

    // Clear and home commands need the long settle; the decision uses the
    // byte already on the pins, which is stable for the whole write cycle.
    always_comb begin
        long_settle = 1'b0;
        settle_last = CMD_LAST;
        if (!lcd_rs_q && (lcd_dat_q == 8'h01 || lcd_dat_q == 8'h02)) begin
            long_settle = 1'b1;
        end
        if (long_settle) begin
            settle_last = CLR_LAST;
        end
    end

    // Next-state logic: sequencing of power wait, init bytes, strobe phases
    // and client acceptance. The counter restarts at zero on every state
    // change and only advances in timed states, so it never wraps.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_dat_d   = lcd_dat_q;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = INIT_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            INIT_LOAD: begin
                lcd_rs_d  = 1'b0;
                lcd_dat_d = init_byte(idx_q);
                state_d   = SETUP;
                cnt_d     = '0;
            end

            SETUP: begin
                if (cnt_q == E_LAST) begin
                    state_d = E_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            E_HIGH: begin
                if (cnt_q == E_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            HOLD: begin
                if (cnt_q == E_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            SETTLE: begin
                if (cnt_q == settle_last) begin
                    cnt_d = '0;
                    if (!init_done_q && idx_q != INIT_LAST_IDX) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = INIT_LOAD;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            IDLE: begin
                if (wr.wr_valid && wr_ready_q) begin
                    lcd_rs_d  = wr.wr_rs;
                    lcd_dat_d = wr.wr_data;
                    state_d   = SETUP;
                    cnt_d     = '0;
                end
            end

            default: begin
                state_d = PWR_WAIT;
                cnt_d   = '0;
            end
        endcase

        // Strobe and ready follow the upcoming state so they come from flops
        // and line up exactly with the state they describe.
        lcd_en_d   = (state_d == E_HIGH);
        wr_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset drops E immediately and restarts the
    // whole power-up and init sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_dat_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            wr_ready_q  <= wr_ready_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_en_q    <= lcd_en_d;
            lcd_dat_q   <= lcd_dat_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign init_done   = init_done_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_en      = lcd_en_q;
    assign lcd_dat     = lcd_dat_q;

endmodule

// File: doc/lcd12864_ctrl.md
# lcd12864_ctrl

Parametrised write-only controller for the ST7920-class 128x64 character/graphic LCD on the board's 8-bit parallel header. It replaces fixed-string LCD drivers: after reset it waits out LCD power-up, runs the standard init sequence by itself, then accepts arbitrary command/data bytes from a client over a valid/ready handshake. It generates correctly timed RS/E/DB strobes, with a long settle time after clear/home commands. Client logic, such as text ROM walkers or counter displays, sits upstream; the LCD pins connect directly.

## Interface
- E_HALF_CYC, 16: clk cycles in each of the setup, E-high and hold phases (≥1)
- CMD_WAIT_CYC, 4000: clk cycles of settle after an ordinary command/data write (≥1)
- CLR_WAIT_CYC, 90000: settle cycles after a clear (0x01) or home (0x02) command (≥1)
- INIT_WAIT_CYC, 2500000: cycles from reset release before the first init write (≥1)

- clk  in  1  system clock (50 MHz on the board)
- rst_n  in  1  asynchronous active-low reset; all state is cleared immediately on assertion
- wr_valid  in  1  client has a byte to write
- wr_ready  out  1  controller accepts a byte this cycle
- wr_rs  in  1  0 = command, 1 = display data
- wr_data  in  8  byte to write
- init_done  out  1  init sequence finished; stays high until reset
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD R/W, tied 0 (write-only)
- lcd_en  out  1  LCD E strobe
- lcd_dat  out  8  LCD DB7..DB0

## Operation
- States: PWR_WAIT, INIT_LOAD, SETUP, E_HIGH, HOLD, SETTLE, IDLE.
- Reset values: lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_dat=0x00, wr_ready=0, init_done=0. State is PWR_WAIT with the counter cleared and the init index at 0.
- PWR_WAIT: count INIT_WAIT_CYC cycles, then go to INIT_LOAD.
- INIT_LOAD: load the init byte at the current index with rs=0, then go to SETUP. The sequence is 0x30 (8-bit basic set), 0x0C (display on, cursor off), 0x06 (entry increment), 0x01 (clear).
- Write cycle:
  - SETUP: lcd_rs/lcd_dat driven, lcd_en=0, for E_HALF_CYC cycles.
  - E_HIGH: lcd_en=1, for E_HALF_CYC cycles.
  - HOLD: lcd_en=0, lcd_rs/lcd_dat unchanged, for E_HALF_CYC cycles.
  - SETTLE: for CLR_WAIT_CYC cycles if rs=0 and byte is 0x01 or 0x02; otherwise for CMD_WAIT_CYC cycles.
- After SETTLE:
  - During init, if the index is below 3, increment it and return to INIT_LOAD.
  - Otherwise set init_done=1 and go to IDLE.
- IDLE: wr_ready=1. A byte is accepted when wr_valid and wr_ready are both 1 at a rising edge. On acceptance, wr_rs/wr_data are captured into lcd_rs/lcd_dat and the state goes to SETUP.
- wr_ready is 0 in every state except IDLE. wr_valid outside IDLE is ignored, and wr_rs/wr_data need not be held stable after acceptance.
- Between writes, lcd_rs/lcd_dat keep their last value; lcd_en is 0 everywhere except E_HIGH.
- Reset asserted mid-write forces lcd_en=0 asynchronously. After release, the full power wait and init sequence rerun.
- Counters are sized by $clog2 of the largest parameter + 1 and never wrap. Each phase counter is reset on entry to its state.

## Timing
- Client write accepted at edge k:
  - lcd_rs/lcd_dat valid from k+1.
  - lcd_en high for cycles k+1+E_HALF_CYC through k+2·E_HALF_CYC inclusive.
  - wr_ready high again at cycle k+1+3·E_HALF_CYC+W, where W is CMD_WAIT_CYC or CLR_WAIT_CYC.
- Back-to-back: a client holding wr_valid high achieves one byte per 1+3·E_HALF_CYC+W cycles.
- Init: the first lcd_en rise occurs INIT_WAIT_CYC+1+E_HALF_CYC cycles after reset release (one cycle for INIT_LOAD). init_done and the first wr_ready rise in the same cycle.
- lcd_dat/lcd_rs never change while lcd_en=1 or during HOLD. Minimum setup and hold are each E_HALF_CYC cycles.

## Test plan
Bench parameters: E_HALF_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=10, INIT_WAIT_CYC=20.
- **Reset/init:** release rst_n.
  - Outputs hold their reset values for 20 cycles.
  - Exactly four lcd_en pulses follow, each 2 cycles wide with rs=0, carrying 0x30, 0x0C, 0x06, 0x01.
  - The gap after 0x01 is 10 cycles.
  - init_done=1 and wr_ready=1 at cycle 20+3·(1+6+4)+(1+6+10)=70.
- **Data write:** after init, send wr_rs=1, wr_data=0x41 with wr_valid for one cycle.
  - lcd_dat=0x41 and lcd_rs=1 from the next cycle.
  - lcd_en high for 2 cycles.
  - wr_ready low for exactly 10 cycles, high on the 11th.
- **Long command:** send wr_rs=0, wr_data=0x02, then wr_rs=0, wr_data=0x80 with wr_valid held high.
  - The first write has a 10-cycle settle and the second a 4-cycle settle.
  - The second byte is accepted exactly 17 cycles after the first.
- **Ignored input:** toggle wr_valid and wr_data randomly while wr_ready=0.
  - lcd_dat never changes outside SETUP entry.
  - No extra lcd_en pulses occur.
- **Mid-write reset:** assert rst_n low during E_HIGH.
  - lcd_en=0 within the same cycle (asynchronous), along with all other reset values.
  - After release, the 20-cycle wait and the 4-byte init sequence repeat and init_done rises again.
- **Stream:** send 32 bytes 0x20..0x3F back-to-back with rs=1.
  - The captured lcd_dat sequence on each lcd_en falling edge matches the input order.
  - Each byte has a 2-cycle lcd_en pulse and the period is 11 cycles.
